seq_alu_ctrl: RTL and testbench



---
 rtl/seq_alu_ctrl_pkg.sv | 29 ++
 rtl/seq_alu_ctrl_btn.sv | 55 +++++
 rtl/seq_alu_ctrl.sv | 159 +++++++++++++++
 tb/tb_seq_alu_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_ctrl_pkg.sv
// Shared encodings for the sequential ALU controller: opcodes, FSM states
// and the bit layout of the comparator output.
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_ADC   = 3'd2,
    OP_AND   = 3'd3,
    OP_OR    = 3'd4,
    OP_XOR   = 3'd5,
    OP_SHL   = 3'd6,
    OP_PASSY = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_WAIT_X = 3'd0,
    ST_WAIT_Y = 3'd1,
    ST_READY  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // CompOut = {lt, gt, eq}
  localparam int CMP_EQ = 0;
  localparam int CMP_GT = 1;
  localparam int CMP_LT = 2;

endpackage

// File: rtl/seq_alu_ctrl_btn.sv
// Button conditioner: 2-FF synchroniser, counter debouncer and a one-cycle
// pulse on each debounced rising edge.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic raw,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised input disagrees with the
  // debounced level; any agreement restarts the stability window.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/seq_alu_ctrl.sv
// Sequential ALU controller: operands loaded from one switch bank by
// debounced button presses, one of eight operations, accumulate chaining.
module seq_alu_ctrl
  import seq_alu_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] Sw,
  input  logic [2:0]       OpSel,
  input  logic             AccMode,
  input  logic             BtnLoad,
  input  logic             BtnExec,
  output logic [WIDTH:0]   Result,
  output logic [2:0]       CompOut,
  output logic             Valid,
  output logic [2:0]       State
);

  localparam int XW = WIDTH + 1;

  logic load_pulse;
  logic exec_pulse;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .raw   (BtnLoad),
    .pulse (load_pulse)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exec (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .raw   (BtnExec),
    .pulse (exec_pulse)
  );

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] opx_q, opx_d;
  logic [WIDTH-1:0] opy_q, opy_d;
  logic [WIDTH:0]   result_q, result_d;
  logic [2:0]       cmp_q, cmp_d;
  logic             valid_q, valid_d;

  logic [WIDTH:0]   x_ext;
  logic [WIDTH:0]   y_ext;
  logic [WIDTH:0]   alu_res;
  logic [2:0]       cmp_now;

  assign x_ext = {1'b0, opx_q};
  assign y_ext = {1'b0, opy_q};

  // The carry flag is Result's top bit; it only moves when EXEC writes Result.
  always_comb begin
    unique case (op_q)
      OP_ADD:   alu_res = x_ext + y_ext;
      OP_SUB:   alu_res = x_ext + {1'b0, ~opy_q} + XW'(1);
      OP_ADC:   alu_res = x_ext + y_ext + XW'(result_q[WIDTH]);
      OP_AND:   alu_res = {1'b0, opx_q & opy_q};
      OP_OR:    alu_res = {1'b0, opx_q | opy_q};
      OP_XOR:   alu_res = {1'b0, opx_q ^ opy_q};
      OP_SHL:   alu_res = {opx_q, 1'b0};
      OP_PASSY: alu_res = y_ext;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    cmp_now         = '0;
    cmp_now[CMP_LT] = (opx_q < opy_q);
    cmp_now[CMP_GT] = (opx_q > opy_q);
    cmp_now[CMP_EQ] = (opx_q == opy_q);
  end

  // Load always takes priority over exec when both pulses coincide.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opx_d    = opx_q;
    opy_d    = opy_q;
    result_d = result_q;
    cmp_d    = cmp_q;
    valid_d  = valid_q;
    unique case (state_q)
      ST_WAIT_X: begin
        if (load_pulse) begin
          opx_d   = Sw;
          state_d = ST_WAIT_Y;
        end
      end
      ST_WAIT_Y: begin
        if (load_pulse) begin
          opy_d   = Sw;
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (load_pulse) begin
          opx_d   = Sw;
          state_d = ST_WAIT_Y;
        end else if (exec_pulse) begin
          op_d    = op_e'(OpSel);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = alu_res;
        cmp_d    = cmp_now;
        valid_d  = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (load_pulse) begin
          opx_d   = Sw;
          valid_d = 1'b0;
          state_d = ST_WAIT_Y;
        end else if (exec_pulse && AccMode) begin
          opx_d   = result_q[WIDTH-1:0];
          valid_d = 1'b0;
          state_d = ST_WAIT_Y;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_WAIT_X;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= ST_WAIT_X;
      op_q     <= OP_ADD;
      opx_q    <= '0;
      opy_q    <= '0;
      result_q <= '0;
      cmp_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opx_q    <= opx_d;
      opy_q    <= opy_d;
      result_q <= result_d;
      cmp_q    <= cmp_d;
      valid_q  <= valid_d;
    end
  end

  assign Result  = result_q;
  assign CompOut = cmp_q;
  assign Valid   = valid_q;
  assign State   = state_q;

endmodule

// File: tb/tb_seq_alu_ctrl.sv
// Bench for seq_alu_ctrl: directed scenarios plus randomized button traffic,
// checked every cycle against a transaction-level model of the controller.
module tb_seq_alu_ctrl;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic [W-1:0] sw       = '0;
  logic [2:0]   opsel    = '0;
  logic         accmode  = 1'b0;
  logic         btn_load = 1'b0;
  logic         btn_exec = 1'b0;
  logic [W:0]   result;
  logic [2:0]   compout;
  logic         valid;
  logic [2:0]   state;

  int checks = 0;
  int passed = 0;
  int txn    = 0;

  seq_alu_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .Clk     (clk),
    .Rst_n   (rst_n),
    .Sw      (sw),
    .OpSel   (opsel),
    .AccMode (accmode),
    .BtnLoad (btn_load),
    .BtnExec (btn_exec),
    .Result  (result),
    .CompOut (compout),
    .Valid   (valid),
    .State   (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: controller state, operands and outputs
  int m_state = 0, m_x = 0, m_y = 0, m_op = 0, m_res = 0, m_cmp = 0, m_valid = 0;
  // Raw button history (index 0 = sample taken at the latest edge), level and pulse
  bit hist[2][D+2];
  bit lvl[2];
  bit pls[2];

  task automatic model_reset();
    m_state = 0; m_x = 0; m_y = 0; m_op = 0; m_res = 0; m_cmp = 0; m_valid = 0;
    for (int b = 0; b < 2; b++) begin
      lvl[b] = 1'b0;
      pls[b] = 1'b0;
      for (int i = 0; i < D + 2; i++) hist[b][i] = 1'b0;
    end
  endtask

  task automatic model_exec();
    int r;
    int c;
    c = m_res >> W;
    case (m_op)
      0: r = m_x + m_y;
      1: r = ((m_x - m_y) & MASK) | ((m_x >= m_y) ? (1 << W) : 0);
      2: r = m_x + m_y + c;
      3: r = m_x & m_y;
      4: r = m_x | m_y;
      5: r = m_x ^ m_y;
      6: r = m_x * 2;
      default: r = m_y;
    endcase
    m_res = r;
    m_cmp = (m_x < m_y) ? 4 : ((m_x > m_y) ? 2 : 1);
  endtask

  task automatic model_fsm(input bit pl, input bit pe);
    case (m_state)
      0: if (pl) begin m_x = sw; m_state = 1; end
      1: if (pl) begin m_y = sw; m_state = 2; end
      2: if (pl) begin m_x = sw; m_state = 1; end
         else if (pe) begin m_op = opsel; m_state = 3; end
      3: begin model_exec(); m_valid = 1; m_state = 4; end
      default: if (pl) begin m_valid = 0; m_x = sw; m_state = 1; end
               else if (pe && accmode) begin m_x = m_res & MASK; m_valid = 0; m_state = 1; end
    endcase
  endtask

  // A button level flips once the synchronised input (raw delayed two edges)
  // has disagreed with it for D consecutive samples.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        bit held;
        model_fsm(pls[0], pls[1]);
        for (int b = 0; b < 2; b++) begin
          for (int i = D + 1; i > 0; i--) hist[b][i] = hist[b][i-1];
          hist[b][0] = (b == 0) ? btn_load : btn_exec;
          held = 1'b1;
          for (int i = 2; i <= D + 1; i++) if (hist[b][i] == lvl[b]) held = 1'b0;
          pls[b] = held && !lvl[b];
          if (held) lvl[b] = !lvl[b];
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("result",  int'(result),     m_res);
      check("compout", int'(compout),    m_cmp);
      check("valid",   int'(valid),      m_valid);
      check("state",   int'(state),      m_state);
      check("opx",     int'(dut.opx_q),  m_x);
    end
  end

  task automatic press(input bit ld, input bit ex, input int hi, input int lo);
    txn++;
    $display("txn %0d: load=%0b exec=%0b sw=0x%02h opsel=%0d acc=%0b high=%0d low=%0d",
             txn, ld, ex, sw, opsel, accmode, hi, lo);
    @(negedge clk);
    btn_load = ld;
    btn_exec = ex;
    repeat (hi) @(negedge clk);
    btn_load = 1'b0;
    btn_exec = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic lit(input string tag, input int r, input int c, input int v, input int s);
    check({tag, "_result"},  int'(result),  r);
    check({tag, "_compout"}, int'(compout), c);
    check({tag, "_valid"},   int'(valid),   v);
    check({tag, "_state"},   int'(state),   s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    lit("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    sw = 8'h5A; press(1, 0, 6, 10);
    sw = 8'h3C; press(1, 0, 6, 10);
    opsel = 3'd0; press(0, 1, 6, 10);
    lit("add", 'h096, 3'b010, 1, 4);

    sw = 8'h10; press(1, 0, 6, 10);
    sw = 8'h20; press(1, 0, 6, 10);
    opsel = 3'd1; press(0, 1, 6, 10);
    lit("sub", 'h0F0, 3'b100, 1, 4);

    // Reset arriving while the FSM sits in EXEC
    sw = 8'h11; press(1, 0, 6, 10);
    sw = 8'h22; press(1, 0, 6, 10);
    @(negedge clk);
    btn_exec = 1'b1;
    repeat (7) @(negedge clk);
    check("pre_reset_state", int'(state), 3);
    #2 rst_n = 1'b0;
    #1 lit("async_reset", 0, 0, 0, 0);
    btn_exec = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Short press and bounce must be filtered out
    sw = 8'h99; press(1, 0, 3, 8);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      btn_load = (i % 2 == 0);
    end
    repeat (8) @(negedge clk);
    check("glitch_state", int'(state), 0);
    check("glitch_opx", int'(dut.opx_q), 0);

    // Clean 10-cycle press: pulse exactly D+2 edges after the raw edge
    sw = 8'hFF;
    @(negedge clk);
    btn_load = 1'b1;
    repeat (5) @(negedge clk);
    check("pulse_early", int'(dut.u_load.pulse), 0);
    @(negedge clk);
    check("pulse_on_time", int'(dut.u_load.pulse), 1);
    @(negedge clk);
    check("pulse_one_cycle", int'(dut.u_load.pulse), 0);
    repeat (3) @(negedge clk);
    btn_load = 1'b0;
    repeat (10) @(negedge clk);
    check("clean_state", int'(state), 1);
    check("clean_opx", int'(dut.opx_q), 'hFF);

    sw = 8'h01; press(1, 0, 6, 10);
    opsel = 3'd0; press(0, 1, 6, 10);
    lit("add_carry", 'h100, 3'b010, 1, 4);
    accmode = 1'b1; press(0, 1, 6, 10);
    accmode = 1'b0;
    check("acc_opx", int'(dut.opx_q), 0);
    check("acc_state", int'(state), 1);
    sw = 8'h05; press(1, 0, 6, 10);
    opsel = 3'd2; press(0, 1, 6, 10);
    lit("adc", 'h006, 3'b100, 1, 4);

    sw = 8'h33; press(1, 0, 6, 10);
    sw = 8'h44; press(1, 0, 6, 10);
    sw = 8'h77; press(1, 1, 6, 10);
    check("both_opx", int'(dut.opx_q), 'h77);
    check("both_state", int'(state), 1);
    check("both_valid", int'(valid), 0);
    sw = 8'h77; press(1, 0, 6, 10);
    opsel = 3'd5; press(0, 1, 6, 10);
    lit("xor", 'h000, 3'b001, 1, 4);
    accmode = 1'b0; press(0, 1, 6, 10);
    lit("exec_ignored", 'h000, 3'b001, 1, 4);

    for (int n = 0; n < 60; n++) begin
      int k;
      sw      = W'($urandom);
      opsel   = 3'($urandom_range(0, 7));
      accmode = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 9);
      if (k < 4)       press(1, 0, $urandom_range(D, D + 3), $urandom_range(D + 3, D + 8));
      else if (k < 8)  press(0, 1, $urandom_range(D, D + 3), $urandom_range(D + 3, D + 8));
      else if (k == 8) press(1, 1, $urandom_range(D, D + 3), $urandom_range(D + 3, D + 8));
      else             press(1'($urandom_range(0, 1)), 1, $urandom_range(1, D - 1), D + 3);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
